dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, data-memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have, per requester p in {0,1} (0 = core LSU, 1 = DMA/debug), ports:
- req_p  input  1  request valid.
- we_p  input  1  1 = store, 0 = load.
- addr_p  input  DM_ADDRESS  byte address.
- wdata_p  input  DATA_W  store data, LSBs used.
- funct3_p  input  3  RISC-V load/store funct3.
- gnt_p  output  1  request accepted this cycle.
- resp_valid_p  output  1  one-cycle completion pulse.
- resp_err_p  output  1  error qualifier, valid with resp_valid_p.
- rdata_p  output  DATA_W  load result, valid with resp_valid_p.
REQ-006 SHALL have memory-side ports:
- mem_raddr  output  32  read address.
- mem_waddr  output  32  word-aligned write address.
- mem_wdata  output  32  lane-replicated write data.
- mem_wr  output  4  byte write enables.
- mem_rdata  input  32  read data, valid one cycle after mem_raddr is stable.

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS, RDATA.
REQ-008 SHALL assert gnt_p combinationally only in IDLE; a request is accepted when req_p & gnt_p at a clock edge.
REQ-009 SHALL keep gnt_0 and gnt_1 mutually exclusive.
REQ-010 SHALL arbitrate round-robin: if only one req is high, grant it; if both are high, grant the port not granted last; the last-grant pointer updates on every grant.
REQ-011 SHALL register the accepted request (port id, we, addr, wdata, funct3) on the grant edge; requesters SHALL hold their fields stable until granted.
REQ-012 SHALL classify an accepted request as an error if:
- funct3 is not in {000, 001, 010, 100, 101}, or
- funct3 = 100/101 with we = 1, or
- halfword with addr[0] = 1, or
- word with addr[1:0] != 0.
REQ-013 On an error request, SHALL perform no memory access, stay in IDLE, and pulse resp_valid_p = 1, resp_err_p = 1, rdata_p = 0 on the cycle after the grant.
REQ-014 On a valid request, SHALL move IDLE -> ACCESS.
REQ-015 In ACCESS and RDATA, SHALL drive mem_raddr = zero-extended addr and mem_waddr = zero-extended {addr[DM_ADDRESS-1:2], 2'b00}.
REQ-016 In ACCESS with a store, SHALL drive mem_wr for exactly one cycle:
- SB: 4'b0001 << addr[1:0], mem_wdata = {4{wdata[7:0]}}.
- SH: 4'b0011 << {addr[1], 1'b0}, mem_wdata = {2{wdata[15:0]}}.
- SW: 4'b1111, mem_wdata = wdata.
After that cycle, SHALL return to IDLE and pulse resp_valid_p (err = 0) on the next cycle.
REQ-017 In ACCESS with a load, SHALL keep mem_wr = 0 and move to RDATA.
REQ-018 In RDATA, SHALL sample mem_rdata, shift it right by 8*addr[1:0], and extract:
- LB: sign-extend byte.
- LH: sign-extend halfword.
- LW: full word.
- LBU: zero-extend byte.
- LHU: zero-extend halfword.
SHALL then return to IDLE and pulse resp_valid_p with rdata_p on the next cycle.
REQ-019 Latency from grant edge T: store resp at T+2; load resp at T+3; error resp at T+1.
REQ-020 SHALL allow a new grant in the IDLE cycle coincident with a response pulse (back-to-back).
REQ-021 SHALL drive mem_wr = 0, mem_raddr = 0, mem_waddr = 0, mem_wdata = 0 in IDLE.
REQ-022 SHALL hold rdata_p at its last value when resp_valid_p = 0; resp_* of the non-owning port stays 0.
REQ-023 SHALL ignore a request that is deasserted before grant, with no side effects.

Reset
REQ-024 While rst_n = 0 at a clock edge, SHALL set state IDLE, last-grant pointer = 1 (port 0 wins first tie), all resp_valid/resp_err = 0, rdata = 0, mem_wr = 0.
REQ-025 Reset asserted in ACCESS or RDATA SHALL abort the operation: no mem_wr on the following cycle and no response pulse.

Verification
REQ-026 Store byte: p0 req we = 1, addr = 0x0D, funct3 = 000, wdata = 0xAB -> gnt_0 at T; mem_wr = 0010, mem_waddr = 0x0C, mem_wdata = 0xABABABAB at T+1; resp_valid_0 = 1 at T+2.
REQ-027 Load signed halfword: memory word 0x8001_7F00 at 0x10; p1 LH addr = 0x12 -> rdata_1 = 0xFFFF8001 at T+3; LHU -> 0x00008001.
REQ-028 Contention: both req held high with continuous loads -> grants alternate 0, 1, 0, 1 starting with port 0 after reset.
REQ-029 Misaligned: SW addr = 0x06 -> no mem_wr ever; resp_valid = 1, resp_err = 1 at T+1; state remains IDLE.
REQ-030 Reset mid-store: rst_n = 0 on the grant edge +1 -> mem_wr stays 0000 and no resp pulse; first post-reset tie is granted to port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin grant between the core LSU (port 0)
// and a DMA/debug requester (port 1). It decodes RISC-V load/store funct3 into
// byte-lane write enables, or into sign/zero-extended load results. Misaligned
// or illegal requests complete immediately with an error response and never
// touch memory.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // port 0 : core LSU
  input  logic                  req_0,
  input  logic                  we_0,
  input  logic [DM_ADDRESS-1:0] addr_0,
  input  logic [DATA_W-1:0]     wdata_0,
  input  logic [2:0]            funct3_0,
  output logic                  gnt_0,
  output logic                  resp_valid_0,
  output logic                  resp_err_0,
  output logic [DATA_W-1:0]     rdata_0,
  // port 1 : DMA / debug
  input  logic                  req_1,
  input  logic                  we_1,
  input  logic [DM_ADDRESS-1:0] addr_1,
  input  logic [DATA_W-1:0]     wdata_1,
  input  logic [2:0]            funct3_1,
  output logic                  gnt_1,
  output logic                  resp_valid_1,
  output logic                  resp_err_1,
  output logic [DATA_W-1:0]     rdata_1,
  // memory side
  output logic [31:0]           mem_raddr,
  output logic [31:0]           mem_waddr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wr,
  input  logic [31:0]           mem_rdata
);

  localparam int WW = (DATA_W < 32) ? DATA_W : 32;

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

  // Illegal funct3, a store with an unsigned-load encoding, or misalignment.
  function automatic logic req_error(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic err;
    err = 1'b0;
    case (f3)
      3'b000:         err = 1'b0;
      3'b001:         err = a[0];
      3'b010:         err = (a != 2'b00);
      3'b100, 3'b101: err = we;
      default:        err = 1'b1;
    endcase
    return err;
  endfunction

  // Byte-lane write enables for SB/SH/SW.
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] m;
    m = 4'b0000;
    case (f3)
      3'b000:  m = 4'b0001 << a;
      3'b001:  m = 4'b0011 << {a[1], 1'b0};
      3'b010:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate store data across every lane so the enables alone select bytes.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] d;
    d = 32'h0000_0000;
    case (f3)
      3'b000:  d = {4{w[7:0]}};
      3'b001:  d = {2{w[15:0]}};
      3'b010:  d = w;
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  // Align the addressed byte to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] d);
    logic [31:0] s;
    logic [31:0] r;
    s = d >> {a, 3'b000};
    r = 32'h0000_0000;
    case (f3)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b010:  r = s;
      3'b100:  r = {24'h00_0000, s[7:0]};
      3'b101:  r = {16'h0000, s[15:0]};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_t                state_r;
  logic                  last_r;
  logic                  port_r;
  logic                  we_r;
  logic [DM_ADDRESS-1:0] addr_r;
  logic [2:0]            funct3_r;
  logic [1:0]            resp_valid_r;
  logic [1:0]            resp_err_r;
  logic [1:0][DATA_W-1:0] rdata_r;
  logic [31:0]           mem_raddr_r;
  logic [31:0]           mem_waddr_r;
  logic [31:0]           mem_wdata_r;
  logic [3:0]            mem_wr_r;

  logic                  sel_s;
  logic [1:0]            gnt_s;
  logic                  accept_s;
  logic                  acc_we_s;
  logic [DM_ADDRESS-1:0] acc_addr_s;
  logic [DM_ADDRESS-1:0] acc_waddr_s;
  logic [31:0]           acc_wdata_s;
  logic [2:0]            acc_funct3_s;
  logic                  acc_err_s;

  // Round-robin selection; grants are only offered while idle.
  always_comb begin
    sel_s = 1'b0;
    gnt_s = 2'b00;
    if (req_0 && req_1) begin
      sel_s = ~last_r;
    end else if (req_1) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
    if (state_r == IDLE) begin
      gnt_s[0] = req_0 & ~sel_s;
      gnt_s[1] = req_1 & sel_s;
    end else begin
      gnt_s = 2'b00;
    end
  end

  // Mux the selected requester's fields and classify them.
  always_comb begin
    acc_we_s     = 1'b0;
    acc_addr_s   = '0;
    acc_wdata_s  = 32'h0000_0000;
    acc_funct3_s = 3'b000;
    if (sel_s) begin
      acc_we_s     = we_1;
      acc_addr_s   = addr_1;
      acc_wdata_s  = 32'(wdata_1[WW-1:0]);
      acc_funct3_s = funct3_1;
    end else begin
      acc_we_s     = we_0;
      acc_addr_s   = addr_0;
      acc_wdata_s  = 32'(wdata_0[WW-1:0]);
      acc_funct3_s = funct3_0;
    end
    acc_waddr_s = {acc_addr_s[DM_ADDRESS-1:2], 2'b00};
    acc_err_s   = req_error(acc_we_s, acc_funct3_s, acc_addr_s[1:0]);
  end

  assign accept_s     = |gnt_s;
  assign gnt_0        = gnt_s[0];
  assign gnt_1        = gnt_s[1];
  assign resp_valid_0 = resp_valid_r[0];
  assign resp_valid_1 = resp_valid_r[1];
  assign resp_err_0   = resp_err_r[0];
  assign resp_err_1   = resp_err_r[1];
  assign rdata_0      = rdata_r[0];
  assign rdata_1      = rdata_r[1];
  assign mem_raddr    = mem_raddr_r;
  assign mem_waddr    = mem_waddr_r;
  assign mem_wdata    = mem_wdata_r;
  // A write already set up when reset arrives must not reach memory.
  assign mem_wr       = mem_wr_r & {4{rst_n}};

  // Access FSM: capture on grant, drive memory, then emit a one-cycle response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_r       <= 1'b1;
      port_r       <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= '0;
      funct3_r     <= 3'b000;
      resp_valid_r <= 2'b00;
      resp_err_r   <= 2'b00;
      rdata_r      <= '0;
      mem_raddr_r  <= 32'h0000_0000;
      mem_waddr_r  <= 32'h0000_0000;
      mem_wdata_r  <= 32'h0000_0000;
      mem_wr_r     <= 4'b0000;
    end else begin
      resp_valid_r <= 2'b00;
      resp_err_r   <= 2'b00;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            last_r   <= sel_s;
            port_r   <= sel_s;
            we_r     <= acc_we_s;
            addr_r   <= acc_addr_s;
            funct3_r <= acc_funct3_s;
            if (acc_err_s) begin
              resp_valid_r[sel_s] <= 1'b1;
              resp_err_r[sel_s]   <= 1'b1;
              rdata_r[sel_s]      <= '0;
            end else begin
              state_r     <= ACCESS;
              mem_raddr_r <= 32'(acc_addr_s);
              mem_waddr_r <= 32'(acc_waddr_s);
              mem_wr_r    <= acc_we_s ? store_mask(acc_funct3_s, acc_addr_s[1:0]) : 4'b0000;
              mem_wdata_r <= acc_we_s ? store_lanes(acc_funct3_s, acc_wdata_s) : 32'h0000_0000;
            end
          end
        end
        ACCESS: begin
          mem_wr_r    <= 4'b0000;
          mem_wdata_r <= 32'h0000_0000;
          if (we_r) begin
            state_r              <= IDLE;
            mem_raddr_r          <= 32'h0000_0000;
            mem_waddr_r          <= 32'h0000_0000;
            resp_valid_r[port_r] <= 1'b1;
            rdata_r[port_r]      <= '0;
          end else begin
            state_r <= RDATA;
          end
        end
        RDATA: begin
          state_r              <= IDLE;
          mem_raddr_r          <= 32'h0000_0000;
          mem_waddr_r          <= 32'h0000_0000;
          resp_valid_r[port_r] <= 1'b1;
          rdata_r[port_r]      <= DATA_W'(load_extract(funct3_r, addr_r[1:0], mem_rdata));
        end
        default: begin
          state_r     <= IDLE;
          mem_raddr_r <= 32'h0000_0000;
          mem_waddr_r <= 32'h0000_0000;
          mem_wdata_r <= 32'h0000_0000;
          mem_wr_r    <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a synchronous-read byte-enable memory model.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req_0, we_0, req_1, we_1;
  logic [8:0]  addr_0, addr_1;
  logic [31:0] wdata_0, wdata_1;
  logic [2:0]  funct3_0, funct3_1;
  logic        gnt_0, gnt_1, resp_valid_0, resp_valid_1, resp_err_0, resp_err_1;
  logic [31:0] rdata_0, rdata_1;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wr;

  logic [31:0] mem [0:127];
  logic        seed;
  int          n_checks = 0;
  int          n_fail   = 0;

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0), .funct3_0(funct3_0),
    .gnt_0(gnt_0), .resp_valid_0(resp_valid_0), .resp_err_0(resp_err_0), .rdata_0(rdata_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1), .funct3_1(funct3_1),
    .gnt_1(gnt_1), .resp_valid_1(resp_valid_1), .resp_err_1(resp_err_1), .rdata_1(rdata_1),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: byte-enabled writes, read data registered one cycle after the address.
  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0000_0000;
      mem[4] <= 32'h8001_7F00;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_wr[b]) mem[mem_waddr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= mem[mem_raddr[8:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic g_gnt(input bit p);  return p ? gnt_1 : gnt_0; endfunction
  function automatic logic g_rv(input bit p);   return p ? resp_valid_1 : resp_valid_0; endfunction
  function automatic logic g_re(input bit p);   return p ? resp_err_1 : resp_err_0; endfunction
  function automatic logic [31:0] g_rd(input bit p); return p ? rdata_1 : rdata_0; endfunction

  task automatic drive(input bit p, input logic we, input logic [8:0] a, input logic [2:0] f,
                       input logic [31:0] wd);
    if (p) begin
      req_1 = 1'b1; we_1 = we; addr_1 = a; funct3_1 = f; wdata_1 = wd;
    end else begin
      req_0 = 1'b1; we_0 = we; addr_0 = a; funct3_0 = f; wdata_0 = wd;
    end
  endtask

  task automatic release_p(input bit p);
    if (p) req_1 = 1'b0; else req_0 = 1'b0;
  endtask

  task automatic do_load(input bit p, input logic [8:0] a, input logic [2:0] f, input logic [31:0] exp);
    @(negedge clk); drive(p, 1'b0, a, f, 32'h0); #1;
    check("ld_gnt", g_gnt(p), 1'b1);
    @(negedge clk);
    check("ld_raddr", mem_raddr, {23'h0, a});
    check("ld_wr", mem_wr, 4'b0000);
    release_p(p);
    @(negedge clk);
    check("ld_early", g_rv(p), 1'b0);
    @(negedge clk);
    check("ld_valid", g_rv(p), 1'b1);
    check("ld_err", g_re(p), 1'b0);
    check("ld_rdata", g_rd(p), exp);
    @(negedge clk);
    check("ld_pulse", g_rv(p), 1'b0);
    check("ld_hold", g_rd(p), exp);
  endtask

  task automatic do_store(input bit p, input logic [8:0] a, input logic [2:0] f, input logic [31:0] wd,
                          input logic [3:0] exp_wr, input logic [31:0] exp_wd);
    @(negedge clk); drive(p, 1'b1, a, f, wd); #1;
    check("st_gnt", g_gnt(p), 1'b1);
    @(negedge clk);
    check("st_wr", mem_wr, exp_wr);
    check("st_wdata", mem_wdata, exp_wd);
    check("st_waddr", mem_waddr, {23'h0, a[8:2], 2'b00});
    release_p(p);
    @(negedge clk);
    check("st_valid", g_rv(p), 1'b1);
    check("st_err", g_re(p), 1'b0);
    check("st_idle_wr", mem_wr, 4'b0000);
  endtask

  task automatic do_err(input bit p, input logic we, input logic [8:0] a, input logic [2:0] f);
    @(negedge clk); drive(p, we, a, f, 32'hFFFF_FFFF); #1;
    check("er_gnt", g_gnt(p), 1'b1);
    @(negedge clk);
    check("er_valid", g_rv(p), 1'b1);
    check("er_err", g_re(p), 1'b1);
    check("er_rdata", g_rd(p), 32'h0);
    check("er_wr", mem_wr, 4'b0000);
    check("er_raddr", mem_raddr, 32'h0);
    check("er_idle", g_gnt(p), 1'b1);
    release_p(p); #1;
    @(negedge clk);
    check("er_pulse", g_rv(p), 1'b0);
    check("er_wr2", mem_wr, 4'b0000);
  endtask

  initial begin
    int gseq[$];
    int gcyc[$];
    int both;
    rst_n = 1'b0; seed = 1'b1;
    req_0 = 1'b0; we_0 = 1'b0; addr_0 = 9'h000; wdata_0 = 32'h0; funct3_0 = 3'b000;
    req_1 = 1'b0; we_1 = 1'b0; addr_1 = 9'h000; wdata_1 = 32'h0; funct3_1 = 3'b000;
    repeat (3) @(negedge clk);
    seed = 1'b0;
    check("rst_rv0", resp_valid_0, 1'b0);
    check("rst_rv1", resp_valid_1, 1'b0);
    check("rst_rd0", rdata_0, 32'h0);
    check("rst_rd1", rdata_1, 32'h0);
    check("rst_wr", mem_wr, 4'b0000);
    check("rst_raddr", mem_raddr, 32'h0);
    rst_n = 1'b1;

    // store byte, observed cycle by cycle
    @(negedge clk); drive(1'b0, 1'b1, 9'h00D, 3'b000, 32'h0000_00AB); #1;
    check("sb_gnt0", gnt_0, 1'b1);
    check("sb_gnt1", gnt_1, 1'b0);
    @(negedge clk);
    check("sb_wr", mem_wr, 4'b0010);
    check("sb_waddr", mem_waddr, 32'h0000_000C);
    check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    check("sb_busy_gnt", gnt_0, 1'b0);
    release_p(1'b0);
    @(negedge clk);
    check("sb_valid", resp_valid_0, 1'b1);
    check("sb_err", resp_err_0, 1'b0);
    check("sb_other", resp_valid_1, 1'b0);
    check("sb_idle_wr", mem_wr, 4'b0000);
    check("sb_idle_waddr", mem_waddr, 32'h0);
    @(negedge clk);
    check("sb_pulse", resp_valid_0, 1'b0);
    check("sb_mem", mem[3], 32'h0000_AB00);

    // loads with every extension mode
    do_load(1'b1, 9'h012, 3'b001, 32'hFFFF_8001);
    do_load(1'b1, 9'h012, 3'b101, 32'h0000_8001);
    do_load(1'b0, 9'h011, 3'b000, 32'h0000_007F);
    do_load(1'b0, 9'h013, 3'b000, 32'hFFFF_FF80);
    do_load(1'b1, 9'h013, 3'b100, 32'h0000_0080);
    do_load(1'b0, 9'h010, 3'b010, 32'h8001_7F00);
    do_load(1'b0, 9'h00D, 3'b100, 32'h0000_00AB);

    // halfword and word stores, read back
    do_store(1'b1, 9'h016, 3'b001, 32'hCAFE_1234, 4'b1100, 32'h1234_1234);
    do_store(1'b0, 9'h020, 3'b010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_load(1'b1, 9'h020, 3'b010, 32'hDEAD_BEEF);
    do_load(1'b0, 9'h016, 3'b101, 32'h0000_1234);

    // errors: misaligned word/halfword, bad funct3, store with unsigned encoding
    do_err(1'b0, 1'b1, 9'h006, 3'b010);
    do_err(1'b1, 1'b0, 9'h010, 3'b011);
    do_err(1'b0, 1'b1, 9'h010, 3'b100);
    do_err(1'b1, 1'b0, 9'h011, 3'b001);
    do_err(1'b0, 1'b1, 9'h013, 3'b001);
    do_err(1'b1, 1'b0, 9'h010, 3'b110);
    check("err_mem", mem[1], 32'h0000_0000);

    // request withdrawn while busy is ignored
    @(negedge clk); drive(1'b0, 1'b0, 9'h010, 3'b010, 32'h0); #1;
    @(negedge clk); release_p(1'b0);
    drive(1'b1, 1'b1, 9'h030, 3'b010, 32'h1111_1111); #1;
    check("wd_gnt_a", gnt_1, 1'b0);
    @(negedge clk); release_p(1'b1); #1;
    check("wd_gnt_b", gnt_1, 1'b0);
    @(negedge clk);
    check("wd_rv0", resp_valid_0, 1'b1);
    check("wd_rd0", rdata_0, 32'h8001_7F00);
    check("wd_rv1", resp_valid_1, 1'b0);
    repeat (2) @(negedge clk);
    check("wd_rv1b", resp_valid_1, 1'b0);
    check("wd_mem", mem[12], 32'h0000_0000);

    // contention after fresh reset: alternate starting with port 0, back-to-back
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 9'h010, 3'b010, 32'h0);
    drive(1'b1, 1'b0, 9'h020, 3'b010, 32'h0);
    both = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (gnt_0 && gnt_1) both++;
      if (gseq.size() < 4 && (gnt_0 || gnt_1)) begin
        gseq.push_back(gnt_1 ? 1 : 0);
        gcyc.push_back(c);
      end
      if (gseq.size() == 4) break;
      @(negedge clk);
    end
    @(negedge clk); release_p(1'b0); release_p(1'b1);
    repeat (4) @(negedge clk);
    check("rr_count", gseq.size(), 4);
    check("rr_mutex", both, 0);
    if (gseq.size() == 4) begin
      check("rr_g0", gseq[0], 0);
      check("rr_g1", gseq[1], 1);
      check("rr_g2", gseq[2], 0);
      check("rr_g3", gseq[3], 1);
      check("rr_gap", gcyc[1] - gcyc[0], 3);
    end

    // reset right after a store grant aborts it
    @(negedge clk); drive(1'b0, 1'b1, 9'h001, 3'b000, 32'h0000_0055); #1;
    check("ra_gnt", gnt_0, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("ra_wr_a", mem_wr, 4'b0000);
    release_p(1'b0);
    @(negedge clk);
    check("ra_wr_b", mem_wr, 4'b0000);
    check("ra_rv_a", resp_valid_0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ra_rv_b", resp_valid_0, 1'b0);
    check("ra_wr_c", mem_wr, 4'b0000);
    check("ra_mem", mem[0], 32'h0000_0000);
    drive(1'b0, 1'b0, 9'h010, 3'b010, 32'h0);
    drive(1'b1, 1'b0, 9'h020, 3'b010, 32'h0); #1;
    check("ra_tie0", gnt_0, 1'b1);
    check("ra_tie1", gnt_1, 1'b0);
    @(negedge clk); release_p(1'b0); release_p(1'b1);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
